// File: rtl/store_checker_pkg.sv
// ============================================================================
// store_checker_pkg
// Shared FSM states, cause codes and expected-store entry for store_checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

package store_checker_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_MISMATCH   = 2'd1;
  localparam logic [1:0] CAUSE_UNEXPECTED = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
    logic        last;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/store_checker_if.sv
// ============================================================================
// store_checker_if
// Processor store bus plus the expected-store load port of store_checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface store_checker_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        exp_valid;
  logic        exp_ready;
  logic [31:0] exp_adr;
  logic [31:0] exp_data;
  logic        exp_last;

  modport master (
    output memwrite, dataadr, writedata,
    output exp_valid, exp_adr, exp_data, exp_last,
    input  exp_ready
  );

  modport slave (
    input  memwrite, dataadr, writedata,
    input  exp_valid, exp_adr, exp_data, exp_last,
    output exp_ready
  );
endinterface

`default_nettype wire

// File: rtl/store_exp_fifo.sv
// ============================================================================
// store_exp_fifo
// Synchronous FIFO of expected stores; pointers carry an extra wrap bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module store_exp_fifo
  import store_checker_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned c_aw = $clog2(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [c_aw:0]   r_wp;
  logic [c_aw:0]   r_rp;
  logic            w_push;
  logic            w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Equal index with differing wrap bit means the writer is a full lap ahead.
  assign empty = (r_wp == r_rp);
  assign full  = (r_wp[c_aw] != r_rp[c_aw]) && (r_wp[c_aw-1:0] == r_rp[c_aw-1:0]);
  assign head  = r_mem[r_rp[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (c_aw+1)'(1);
      if (w_pop)  r_rp <= r_rp + (c_aw+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[c_aw-1:0]] <= push_entry;
  end

endmodule

`default_nettype wire

// File: rtl/store_checker.sv
// ============================================================================
// store_checker
// Compares every data-memory store against a queue of expected stores and
// reports registered pass/fail status, fail cause and timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module store_checker
  import store_checker_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned IGNORE_EN  = 1,
  parameter int unsigned IGNORE_ADR = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  store_checker_if.slave        bus,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [1:0]            cause,
  output logic [31:0]           err_adr,
  output logic [31:0]           err_data,
  output logic [15:0]           store_count,
  output logic [31:0]           cycle_count
);

  state_t      r_state;
  logic        r_done;
  logic        r_pass;
  logic        r_fail;
  logic [1:0]  r_cause;
  logic [31:0] r_err_adr;
  logic [31:0] r_err_data;
  logic [15:0] r_store_count;
  logic [31:0] r_cycle_count;

  entry_t      w_head;
  entry_t      w_push_entry;
  logic        w_full;
  logic        w_empty;
  logic        w_event;
  logic        w_ignored;
  logic        w_checked;
  logic        w_match;
  logic        w_pop;
  logic [31:0] w_cycle_next;

  assign w_push_entry.adr  = bus.exp_adr;
  assign w_push_entry.data = bus.exp_data;
  assign w_push_entry.last = bus.exp_last;

  // Pushes stay open after the run ends; ready only reflects occupancy.
  store_exp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.exp_valid),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty)
  );

  assign bus.exp_ready = !w_full;

  assign w_event      = bus.memwrite && (r_state == ST_RUN);
  assign w_ignored    = (IGNORE_EN != 0) && (bus.dataadr == IGNORE_ADR);
  assign w_checked    = w_event && !w_ignored;
  assign w_match      = !w_empty && (w_head.adr == bus.dataadr) && (w_head.data == bus.writedata);
  assign w_pop        = w_checked && w_match;
  assign w_cycle_next = r_cycle_count + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_cause       <= CAUSE_NONE;
      r_err_adr     <= '0;
      r_err_data    <= '0;
      r_store_count <= '0;
      r_cycle_count <= '0;
    end else if (r_state == ST_RUN) begin
      r_cycle_count <= w_cycle_next;
      // Mismatching stores are counted too; only an empty queue skips the count.
      if (w_checked && !w_empty) r_store_count <= r_store_count + 16'd1;

      if (w_checked && w_empty) begin
        r_state    <= ST_FAIL;
        r_done     <= 1'b1;
        r_fail     <= 1'b1;
        r_cause    <= CAUSE_UNEXPECTED;
        r_err_adr  <= bus.dataadr;
        r_err_data <= bus.writedata;
      end else if (w_checked && !w_match) begin
        r_state    <= ST_FAIL;
        r_done     <= 1'b1;
        r_fail     <= 1'b1;
        r_cause    <= CAUSE_MISMATCH;
        r_err_adr  <= bus.dataadr;
        r_err_data <= bus.writedata;
      end else if (w_pop && w_head.last) begin
        r_state <= ST_PASS;
        r_done  <= 1'b1;
        r_pass  <= 1'b1;
      end else if (w_cycle_next == MAX_CYCLES) begin
        r_state <= ST_FAIL;
        r_done  <= 1'b1;
        r_fail  <= 1'b1;
        r_cause <= CAUSE_TIMEOUT;
      end
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign cause       = r_cause;
  assign err_adr     = r_err_adr;
  assign err_data    = r_err_data;
  assign store_count = r_store_count;
  assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_store_checker.sv
// ============================================================================
// tb_store_checker
// Directed self-checking bench for store_checker (DEPTH=4, MAX_CYCLES=20).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_store_checker;

  logic        clk;
  logic        reset;
  logic        done;
  logic        pass;
  logic        fail;
  logic [1:0]  cause;
  logic [31:0] err_adr;
  logic [31:0] err_data;
  logic [15:0] store_count;
  logic [31:0] cycle_count;

  int n_checks;
  int n_errors;
  int acc;

  store_checker_if bus ();

  store_checker #(
    .DEPTH      (4),
    .MAX_CYCLES (20),
    .IGNORE_EN  (1),
    .IGNORE_ADR (80)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .cause       (cause),
    .err_adr     (err_adr),
    .err_data    (err_data),
    .store_count (store_count),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.memwrite  = 1'b0;
    bus.exp_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] adr, input logic [31:0] data, input logic last);
    bus.exp_valid = 1'b1;
    bus.exp_adr   = adr;
    bus.exp_data  = data;
    bus.exp_last  = last;
    tick();
    bus.exp_valid = 1'b0;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    bus.memwrite  = 1'b1;
    bus.dataadr   = adr;
    bus.writedata = data;
    tick();
    bus.memwrite  = 1'b0;
  endtask

  // Holds exp_valid for n cycles; entry k is (200+4k, 10+k), last on k==3.
  task automatic fill(input int n, output int accepted);
    logic ready_now;
    accepted = 0;
    bus.exp_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.exp_adr  = 32'(200 + 4 * accepted);
      bus.exp_data = 32'(10 + accepted);
      bus.exp_last = (accepted == 3);
      ready_now    = bus.exp_ready;
      tick();
      if (ready_now) accepted++;
    end
    bus.exp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    bus.exp_valid = 1'b0;
    bus.exp_adr   = '0;
    bus.exp_data  = '0;
    bus.exp_last  = 1'b0;

    // Reset state
    do_reset();
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_cause", 32'(cause), 0);
    check("rst_err_adr", err_adr, 0);
    check("rst_err_data", err_data, 0);
    check("rst_store_count", 32'(store_count), 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_exp_ready", 32'(bus.exp_ready), 1);

    // 1: ignored scratch store, then matching last store
    push(84, 7, 1'b1);
    store(80, 3);
    check("t1_ignored_pass", 32'(pass), 0);
    check("t1_ignored_count", 32'(store_count), 0);
    store(84, 7);
    check("t1_pass", 32'(pass), 1);
    check("t1_done", 32'(done), 1);
    check("t1_fail", 32'(fail), 0);
    check("t1_cause", 32'(cause), 0);
    check("t1_store_count", 32'(store_count), 1);
    store(84, 7);
    tick();
    check("t1_frozen_count", 32'(store_count), 1);
    check("t1_frozen_cycles", cycle_count, 3);

    // 2: data mismatch keeps the head entry
    do_reset();
    push(84, 7, 1'b1);
    store(84, 6);
    check("t2_fail", 32'(fail), 1);
    check("t2_pass", 32'(pass), 0);
    check("t2_cause", 32'(cause), 1);
    check("t2_err_adr", err_adr, 84);
    check("t2_err_data", err_data, 6);
    check("t2_store_count", 32'(store_count), 1);
    fill(6, acc);
    check("t2_room_left", 32'(acc), 3);
    check("t2_exp_ready", 32'(bus.exp_ready), 0);

    // 3: store with empty queue, and with a same-cycle push
    do_reset();
    store(100, 5);
    check("t3_fail", 32'(fail), 1);
    check("t3_cause", 32'(cause), 2);
    check("t3_err_adr", err_adr, 100);
    check("t3_err_data", err_data, 5);
    check("t3_store_count", 32'(store_count), 0);
    do_reset();
    bus.exp_valid = 1'b1;
    bus.exp_adr   = 100;
    bus.exp_data  = 5;
    bus.exp_last  = 1'b1;
    store(100, 5);
    bus.exp_valid = 1'b0;
    check("t3b_cause", 32'(cause), 2);
    check("t3b_pass", 32'(pass), 0);

    // 4: timeout at MAX_CYCLES, and store winning on the same edge
    do_reset();
    for (int i = 0; i < 19; i++) tick();
    check("t4_not_yet", 32'(fail), 0);
    check("t4_cycles19", cycle_count, 19);
    tick();
    check("t4_fail", 32'(fail), 1);
    check("t4_cause", 32'(cause), 3);
    check("t4_cycles20", cycle_count, 20);
    check("t4_err_adr", err_adr, 0);
    tick();
    check("t4_frozen", cycle_count, 20);
    do_reset();
    push(84, 7, 1'b1);
    for (int i = 0; i < 18; i++) tick();
    check("t4b_not_yet", 32'(done), 0);
    store(84, 7);
    check("t4b_pass", 32'(pass), 1);
    check("t4b_fail", 32'(fail), 0);
    check("t4b_cause", 32'(cause), 0);
    check("t4b_cycles", cycle_count, 20);

    // 5: fill to DEPTH then drain with four matching stores
    do_reset();
    fill(6, acc);
    check("t5_accepted", 32'(acc), 4);
    check("t5_full", 32'(bus.exp_ready), 0);
    for (int i = 0; i < 4; i++) store(32'(200 + 4 * i), 32'(10 + i));
    check("t5_pass", 32'(pass), 1);
    check("t5_fail", 32'(fail), 0);
    check("t5_store_count", 32'(store_count), 4);
    check("t5_drained", 32'(bus.exp_ready), 1);

    // 6: mid-run reset clears everything, including an in-flight push
    do_reset();
    push(300, 1, 1'b0);
    push(304, 2, 1'b0);
    push(308, 3, 1'b1);
    store(300, 1);
    store(304, 2);
    check("t6_mid_count", 32'(store_count), 2);
    bus.exp_valid = 1'b1;
    bus.exp_adr   = 308;
    bus.exp_data  = 3;
    bus.exp_last  = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.exp_valid = 1'b0;
    check("t6_done", 32'(done), 0);
    check("t6_cause", 32'(cause), 0);
    check("t6_store_count", 32'(store_count), 0);
    check("t6_cycle_count", cycle_count, 0);
    check("t6_exp_ready", 32'(bus.exp_ready), 1);
    store(308, 3);
    check("t6_queue_empty", 32'(cause), 2);
    check("t6_no_pass", 32'(pass), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_checker.md
# store_checker

Synthesizable pass/fail checker that consumes the data-memory write bus of the multicycle MIPS top level (`memwrite`, `dataadr`, `writedata`). It compares every store against a queue of expected stores, loaded through a valid/ready port. It reports pass, fail, cause and timeout as registered status. It sits beside `topmulti` in simulation and FPGA bring-up, replacing ad-hoc negedge checks with a clocked, reusable monitor.

## Interface

**Parameters**
- `DEPTH`, default 8: expected-store queue depth; a power of two, at least 2.
- `MAX_CYCLES`, default 1000: run-cycle limit before timeout fail.
- `IGNORE_EN`, default 1: when 1, stores to `IGNORE_ADR` are not checked.
- `IGNORE_ADR`, default 80: scratch address excluded from checking.

**Ports**
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `memwrite` in 1: store strobe from the DUT.
- `dataadr` in 32: store address.
- `writedata` in 32: store data.
- `exp_valid` in 1: expected entry offered.
- `exp_ready` out 1: queue can accept an entry; equals not-full.
- `exp_adr` in 32, `exp_data` in 32: expected store.
- `exp_last` in 1: a match on this entry ends the run with pass.
- `done` out 1: run finished, sticky.
- `pass` out 1: finished successfully.
- `fail` out 1: finished unsuccessfully.
- `cause` out 2: fail reason; 0 none, 1 mismatch, 2 unexpected store, 3 timeout.
- `err_adr` out 32, `err_data` out 32: offending store's address and data; 0 if not applicable.
- `store_count` out 16: number of checked stores.
- `cycle_count` out 32: cycles spent in RUN.

## Operation

- **States:** RUN, PASS, FAIL. Reset enters RUN.
- **Reset values:** queue empty; all outputs 0 except `exp_ready`, which is 1.
- **Store event:** `memwrite` is 1 at a rising edge in RUN. One event is counted per such edge, with no edge detection.
- **Ignored stores:** if `IGNORE_EN` is 1 and `dataadr` equals `IGNORE_ADR`, the event is dropped. It is not counted and does not pop the queue.
- **Checked stores:**
  - Queue empty: go to FAIL, `cause`=2, latch `err_adr`/`err_data`.
  - Head matches both address and data: pop, increment `store_count`. If head `exp_last` is set, go to PASS.
  - Head mismatches: go to FAIL, `cause`=1, latch the observed address/data. `store_count` still increments. The head is not popped.
- **Timeout:** in RUN, `cycle_count` increments every cycle. If no store decides the run, reaching `MAX_CYCLES` moves to FAIL with `cause`=3 and err fields 0.
- **PASS/FAIL:** sticky until reset. Further stores are ignored, counters freeze, and queue pushes are still accepted.
- **Arithmetic:**
  - `store_count` wraps at 2^16.
  - The timeout compare uses `cycle_count` after increment, so fail is registered at the edge where the count becomes `MAX_CYCLES`.

## Timing

- A store is sampled at the rising edge. Status registers update at that same edge and are visible in the following cycle, i.e. latency 1.
- **Push:** occurs on a rising edge with `exp_valid` and `exp_ready` both high. `exp_ready` depends only on the registered occupancy.
- **Simultaneous push and store event:** the compare uses the queue before the push (no bypass). A push into an empty queue in the same cycle as a store therefore yields `cause`=2.
- **Simultaneous pop and push when full:** not possible, because `exp_ready` is 0 when full.
- **Same edge store decision and timeout:** the store decision wins. A matching `exp_last` store gives PASS even at `MAX_CYCLES`.
- **`done`** equals `pass | fail`. `pass` and `fail` are never both 1.
- **Reset asserted mid-run:** at the next edge, the queue, state and counters clear. Any in-flight push is discarded.

## Structure

- **Shared package `store_checker_pkg`:**
  - state enum (RUN/PASS/FAIL);
  - cause codes: `CAUSE_NONE`, `CAUSE_MISMATCH`, `CAUSE_UNEXPECTED`, `CAUSE_TIMEOUT`;
  - the 65-bit entry struct {adr, data, last}.
- **Sub-module `store_exp_fifo`:** synchronous FIFO of DEPTH entries with push/pop, full/empty, and pointers with an extra wrap bit.
- The top level holds the FSM, compare logic and counters.

## Test plan

1. Push (84,7,last). Drive stores (80,3) then (84,7). Expected: PASS one cycle after the second store, `store_count`=1, `cause`=0.
2. Push (84,7,last). Drive store (84,6). Expected: FAIL, `cause`=1, `err_adr`=84, `err_data`=6, queue still holds 1 entry.
3. Queue empty. Drive store (100,5). Expected: FAIL, `cause`=2, `err_adr`=100. Separately, with a push into the empty queue in the same cycle as the store: still `cause`=2.
4. `MAX_CYCLES`=20, no stores. Expected: FAIL with `cause`=3 visible after the 20th post-reset edge, `cycle_count`=20. A matching last store on that same edge instead yields PASS.
5. `DEPTH`=4, hold `exp_valid` for 6 cycles. Expected: `exp_ready` drops after 4 accepted entries. Then four matching stores (last on the 4th) give PASS, `store_count`=4.
6. Reset for one cycle after 2 of 3 expected stores have matched. Expected: all status and counts return to 0, queue empty, `exp_ready`=1.
